// File: rtl/adc_trig_capture.sv
// rtl/adc_trig_capture.sv - paced N-channel ADC capture with circular pretrigger window and level/slope trigger
// Optional timeout auto-trigger (parameter AUTO_TMO, port auto_trig) enabled by macro ADC_AUTO_TRIG_EN.
module adc_trig_capture #(
  parameter int DW   = 8,
  parameter int NCH  = 2,
  parameter int AW   = 12,
  parameter int DIVW = 20,
  parameter int CSW  = 1
`ifdef ADC_AUTO_TRIG_EN
  ,
  parameter int AUTO_TMO = 1 << 20
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*DW-1:0] sample_in,
  input  logic [DIVW-1:0]   sample_divider,
  input  logic [AW-1:0]     pretrig_len,
  input  logic [CSW-1:0]    trig_ch,
  input  logic [DW-1:0]     trig_level,
  input  logic              trig_slope,
  input  logic              single,
  input  logic              arm,
  input  logic              force_trig,
  input  logic              update_en,
  output logic [AW-1:0]     mem_addr,
  output logic [NCH*DW-1:0] mem_data,
  output logic              mem_wen,
  output logic [AW-1:0]     trig_addr,
  output logic              done,
  output logic [2:0]        state
`ifdef ADC_AUTO_TRIG_EN
  ,
  output logic              auto_trig
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q;
  logic [DIVW-1:0]   div_q;
  logic [AW-1:0]     wptr_q, pre_cnt_q, plen_q, trig_addr_q;
  logic [AW:0]       post_cnt_q;
  logic [CSW-1:0]    ch_q;
  logic [DW-1:0]     level_q, prev_q;
  logic              slope_q, single_q;
  logic              wen_q, done_q, fin_q, force_q;
  logic [NCH*DW-1:0] data_q;

  logic [AW-1:0]     plen_in, start_plen;
  logic [AW:0]       post_len;
  logic [DW-1:0]     cur;
  logic              active, strobe, crossed, start, trig, tmo_hit;

  // Keep at least two POST samples so the trigger sample is never the last write.
  assign plen_in    = (&pretrig_len) ? {{(AW-1){1'b1}}, 1'b0} : pretrig_len;
  assign start_plen = arm ? plen_in : plen_q;
  assign post_len   = {1'b1, {AW{1'b0}}} - {1'b0, plen_q};

  always_comb begin
    cur = '0;
    for (int i = 0; i < NCH; i++)
      if (ch_q == CSW'(i)) cur = sample_in[i*DW +: DW];
  end

  assign active  = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
  // fin_q holds off strobes while the final POST write drains.
  assign strobe  = active && !fin_q && (div_q >= sample_divider);
  assign crossed = slope_q ? ((prev_q < level_q) && (cur >= level_q))
                           : ((prev_q > level_q) && (cur <= level_q));
  assign start   = ((state_q == S_IDLE) && arm) ||
                   ((state_q == S_DONE) && update_en && (arm || !single_q));

`ifdef ADC_AUTO_TRIG_EN
  localparam int TMOW = $clog2(AUTO_TMO + 1);
  logic [TMOW-1:0] tmo_q;
  logic            auto_q;
  assign tmo_hit   = (tmo_q >= TMOW'(AUTO_TMO));
  assign auto_trig = auto_q;
`else
  assign tmo_hit = 1'b0;
`endif

  assign trig = (state_q == S_ARMED) && strobe && (crossed || force_q || force_trig || tmo_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      wptr_q      <= '0;
      pre_cnt_q   <= '0;
      plen_q      <= '0;
      trig_addr_q <= '0;
      post_cnt_q  <= '0;
      ch_q        <= '0;
      level_q     <= '0;
      prev_q      <= '0;
      slope_q     <= 1'b0;
      single_q    <= 1'b0;
      wen_q       <= 1'b0;
      done_q      <= 1'b0;
      fin_q       <= 1'b0;
      force_q     <= 1'b0;
      data_q      <= '0;
`ifdef ADC_AUTO_TRIG_EN
      tmo_q       <= '0;
      auto_q      <= 1'b0;
`endif
    end else begin
      wen_q <= strobe;
      if (strobe) data_q <= sample_in;
      if (wen_q) wptr_q <= wptr_q + AW'(1);
      if (strobe && ((state_q == S_PRE) || (state_q == S_ARMED))) prev_q <= cur;

      if (start) div_q <= '0;
      else if (active) div_q <= (div_q >= sample_divider) ? '0 : div_q + DIVW'(1);

      if (force_trig && (state_q == S_ARMED)) force_q <= 1'b1;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (arm) begin
              plen_q   <= plen_in;
              ch_q     <= trig_ch;
              level_q  <= trig_level;
              slope_q  <= trig_slope;
              single_q <= single;
`ifdef ADC_AUTO_TRIG_EN
              auto_q   <= 1'b0;
`endif
            end
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            fin_q      <= 1'b0;
            force_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef ADC_AUTO_TRIG_EN
            tmo_q      <= '0;
`endif
            state_q    <= (start_plen == '0) ? S_ARMED : S_PRE;
          end
        end
        S_PRE: begin
          if (strobe) begin
            pre_cnt_q <= pre_cnt_q + AW'(1);
            if (pre_cnt_q == plen_q - AW'(1)) begin
              state_q <= S_ARMED;
`ifdef ADC_AUTO_TRIG_EN
              tmo_q   <= '0;
`endif
            end
          end
        end
        S_ARMED: begin
`ifdef ADC_AUTO_TRIG_EN
          if (!tmo_hit) tmo_q <= tmo_q + TMOW'(1);
`endif
          if (trig) begin
            // The trigger sample lands one slot later if a write is in flight.
            trig_addr_q <= wptr_q + AW'(wen_q);
            post_cnt_q  <= (AW+1)'(1);
            force_q     <= 1'b0;
            state_q     <= S_POST;
`ifdef ADC_AUTO_TRIG_EN
            auto_q      <= !crossed && !force_q && !force_trig;
`endif
          end
        end
        S_POST: begin
          if (strobe) begin
            post_cnt_q <= post_cnt_q + (AW+1)'(1);
            if (post_cnt_q + (AW+1)'(1) == post_len) fin_q <= 1'b1;
          end
          if (fin_q && wen_q) begin
            fin_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr  = wptr_q;
  assign mem_data  = data_q;
  assign mem_wen   = wen_q;
  assign trig_addr = trig_addr_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule
